// File: rtl/otp_macro_emu_if.sv
// Pin bundle between an OTP controller (master) and the OTP array
// responder (slave). The signal names match the controller's pin names.
interface otp_macro_emu_if;
    logic       i_otp_csb;
    logic       i_otp_strobe;
    logic       i_otp_load;
    logic       i_otp_pgenb;
    logic       i_otp_vddqsw;
    logic [6:0] i_otp_addr;
    logic       i_err_clr;
    logic [7:0] o_otp_q;
    logic       o_busy;
    logic [3:0] o_err;
    logic [7:0] o_pg_cnt;

    modport master (
        output i_otp_csb, i_otp_strobe, i_otp_load, i_otp_pgenb,
               i_otp_vddqsw, i_otp_addr, i_err_clr,
        input  o_otp_q, o_busy, o_err, o_pg_cnt
    );

    modport slave (
        input  i_otp_csb, i_otp_strobe, i_otp_load, i_otp_pgenb,
               i_otp_vddqsw, i_otp_addr, i_err_clr,
        output o_otp_q, o_busy, o_err, o_pg_cnt
    );
endinterface

// File: rtl/otp_macro_emu.sv
// OTP array emulator: a 16 x 8 one-time-programmable array that answers the
// controller's strobe-based read/program protocol, checks pulse widths and
// mode legality, and reports protocol violations in sticky error flags.
module otp_macro_emu #(
    parameter int           RD_MIN = 2,
    parameter int           PG_MIN = 6,
    parameter logic [127:0] INIT   = 128'h0
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    otp_macro_emu_if.slave bus
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        STBY = 2'd1,
        RD   = 2'd2,
        PG   = 2'd3
    } state_t;

    localparam logic [7:0] RD_MIN_C = RD_MIN[7:0];
    localparam logic [7:0] PG_MIN_C = PG_MIN[7:0];

    // Saturating 8-bit increment shared by the pulse counter and program count.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 8'h01;
        end
    endfunction

    state_t     state_r;
    state_t     state_next;
    logic       strobe_d_r;
    logic [6:0] addr_r;
    logic [7:0] cnt_r;
    logic [7:0] cnt_next;
    logic       failed_r;
    logic       failed_next;
    logic [7:0] q_r;
    logic [3:0] err_r;
    logic [7:0] pg_cnt_r;
    logic       busy_r;
    logic [7:0] mem_r [16];

    logic       rise_s;
    logic       entry_s;
    logic       rd_done_s;
    logic       pg_done_s;
    logic [3:0] err_set_s;

    assign rise_s = bus.i_otp_strobe & ~strobe_d_r;

    // Next-state decode plus the per-cycle access/error events.
    always_comb begin
        state_next  = state_r;
        cnt_next    = cnt_r;
        failed_next = failed_r;
        entry_s     = 1'b0;
        rd_done_s   = 1'b0;
        pg_done_s   = 1'b0;
        err_set_s   = 4'h0;

        case (state_r)
            OFF: begin
                if (!bus.i_otp_csb) begin
                    state_next = STBY;
                end else begin
                    state_next = OFF;
                end
            end

            STBY: begin
                if (bus.i_otp_csb && !bus.i_otp_strobe) begin
                    state_next = OFF;
                end else if (rise_s) begin
                    if (bus.i_otp_load && bus.i_otp_pgenb) begin
                        state_next = RD;
                        entry_s    = 1'b1;
                    end else if (!bus.i_otp_load && !bus.i_otp_pgenb && bus.i_otp_vddqsw) begin
                        state_next = PG;
                        entry_s    = 1'b1;
                    end else begin
                        err_set_s[1] = 1'b1;
                    end
                end else begin
                    state_next = STBY;
                end
            end

            RD: begin
                if (bus.i_otp_addr != addr_r) begin
                    err_set_s[2] = 1'b1;
                end else begin
                    err_set_s[2] = 1'b0;
                end
                if (bus.i_otp_csb) begin
                    err_set_s[3] = 1'b1;
                    state_next   = OFF;
                end else if (bus.i_otp_strobe) begin
                    cnt_next = sat_inc(cnt_r);
                end else begin
                    // Strobe fall: deliver data only for a long enough pulse.
                    if (cnt_r >= RD_MIN_C) begin
                        rd_done_s = 1'b1;
                    end else begin
                        err_set_s[0] = 1'b1;
                    end
                    state_next = STBY;
                end
            end

            PG: begin
                if (bus.i_otp_addr != addr_r) begin
                    err_set_s[2] = 1'b1;
                end else begin
                    err_set_s[2] = 1'b0;
                end
                // Any cycle without program supply spoils the whole operation.
                if (!bus.i_otp_vddqsw) begin
                    err_set_s[1] = 1'b1;
                    failed_next  = 1'b1;
                end else begin
                    failed_next  = failed_r;
                end
                if (bus.i_otp_csb) begin
                    err_set_s[3] = 1'b1;
                    state_next   = OFF;
                end else if (bus.i_otp_strobe) begin
                    cnt_next = sat_inc(cnt_r);
                end else begin
                    if ((cnt_r >= PG_MIN_C) && !failed_next) begin
                        pg_done_s = 1'b1;
                    end else if (cnt_r < PG_MIN_C) begin
                        err_set_s[0] = 1'b1;
                    end else begin
                        pg_done_s = 1'b0;
                    end
                    state_next = STBY;
                end
            end

            default: begin
                state_next = OFF;
            end
        endcase

        // A fresh access always starts with a clean counter and status.
        if (entry_s) begin
            cnt_next    = 8'h00;
            failed_next = 1'b0;
        end else begin
            cnt_next    = cnt_next;
        end
    end

    // FSM state, strobe history and per-access context registers.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_r    <= OFF;
            strobe_d_r <= 1'b0;
            cnt_r      <= 8'h00;
            failed_r   <= 1'b0;
            addr_r     <= 7'h00;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next;
            strobe_d_r <= bus.i_otp_strobe;
            cnt_r      <= cnt_next;
            failed_r   <= failed_next;
            if (entry_s) begin
                addr_r <= bus.i_otp_addr;
            end
            busy_r     <= (state_next == RD) || (state_next == PG);
        end
    end

    // Read data register: only a completed read changes it.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            q_r <= 8'h00;
        end else if (rd_done_s) begin
            q_r <= mem_r[addr_r[6:3]];
        end
    end

    // Sticky error flags; a new error in the clear cycle still lands.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            err_r <= 4'h0;
        end else begin
            err_r <= (bus.i_err_clr ? 4'h0 : err_r) | err_set_s;
        end
    end

    // Successful program counter, saturating.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            pg_cnt_r <= 8'h00;
        end else if (pg_done_s) begin
            pg_cnt_r <= sat_inc(pg_cnt_r);
        end
    end

    // Fuse array: bits can only be blown to 1; reset restores INIT.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= INIT[i*8 +: 8];
            end
        end else if (pg_done_s) begin
            mem_r[addr_r[6:3]][addr_r[2:0]] <= 1'b1;
        end
    end

    assign bus.o_otp_q  = q_r;
    assign bus.o_busy   = busy_r;
    assign bus.o_err    = err_r;
    assign bus.o_pg_cnt = pg_cnt_r;

endmodule

// File: tb/tb_otp_macro_emu.sv
// Self-checking bench for otp_macro_emu: directed protocol scenarios followed
// by randomized read/program traffic, checked against a transaction-level
// model of the fuse array, read register, error flags and program count.
module tb_otp_macro_emu;

    localparam int RD_MIN = 2;
    localparam int PG_MIN = 6;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    otp_macro_emu_if bus ();

    otp_macro_emu #(
        .RD_MIN (RD_MIN),
        .PG_MIN (PG_MIN),
        .INIT   (128'h0)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model state.
    logic [7:0] m_mem [16];
    logic [7:0] m_q;
    logic [3:0] m_err;
    logic [7:0] m_pg;

    int n_total = 0;
    int n_pass  = 0;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},    bus.o_otp_q, m_q);
        check({tag, ".err"},  {4'h0, bus.o_err}, {4'h0, m_err});
        check({tag, ".pg"},   bus.o_pg_cnt, m_pg);
        check({tag, ".busy"}, {7'h00, bus.o_busy}, 8'h00);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_q   = 8'h00;
        m_err = 4'h0;
        m_pg  = 8'h00;
    endtask

    task automatic idle_pins();
        bus.i_otp_strobe = 1'b0;
        bus.i_otp_load   = 1'b0;
        bus.i_otp_pgenb  = 1'b1;
        bus.i_otp_vddqsw = 1'b0;
        bus.i_err_clr    = 1'b0;
    endtask

    // Read with an N-cycle strobe; toggle_at >= 1 changes the address mid-read.
    task automatic do_read(input logic [6:0] a, input int len, input int toggle_at);
        bus.i_otp_load   = 1'b1;
        bus.i_otp_pgenb  = 1'b1;
        bus.i_otp_vddqsw = 1'b0;
        bus.i_otp_addr   = a;
        bus.i_otp_strobe = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i == toggle_at) bus.i_otp_addr = a ^ 7'h08;
            tick();
            if (i == 0) check("rd.busy_on", {7'h00, bus.o_busy}, 8'h01);
        end
        bus.i_otp_strobe = 1'b0;
        tick();
        bus.i_otp_addr = a;
        tick();
        idle_pins();
        if (toggle_at >= 1 && toggle_at < len) m_err = m_err | 4'h4;
        if (len - 1 >= RD_MIN) m_q = m_mem[a[6:3]];
        else m_err = m_err | 4'h1;
    endtask

    // Program with an N-cycle strobe; drop in [1,len-1] removes vddqsw from that cycle on.
    task automatic do_prog(input logic [6:0] a, input int len, input int drop);
        logic failed;
        bus.i_otp_load   = 1'b0;
        bus.i_otp_pgenb  = 1'b0;
        bus.i_otp_vddqsw = 1'b1;
        bus.i_otp_addr   = a;
        bus.i_otp_strobe = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i == drop) bus.i_otp_vddqsw = 1'b0;
            tick();
        end
        bus.i_otp_strobe = 1'b0;
        tick();
        idle_pins();
        tick();
        failed = (drop >= 1) && (drop < len);
        if (failed) m_err = m_err | 4'h2;
        if ((len - 1 >= PG_MIN) && !failed) begin
            m_mem[a[6:3]] = m_mem[a[6:3]] | (8'h01 << a[2:0]);
            if (m_pg != 8'hFF) m_pg = m_pg + 8'h01;
        end else if (len - 1 < PG_MIN) begin
            m_err = m_err | 4'h1;
        end
    endtask

    // Strobe rise with load=1, pgenb=0: rejected, optionally with err_clr in the same cycle.
    task automatic do_illegal(input logic clr);
        bus.i_otp_load   = 1'b1;
        bus.i_otp_pgenb  = 1'b0;
        bus.i_otp_strobe = 1'b1;
        bus.i_err_clr    = clr;
        tick();
        bus.i_err_clr    = 1'b0;
        check("ill.busy", {7'h00, bus.o_busy}, 8'h00);
        tick();
        check("ill.busy2", {7'h00, bus.o_busy}, 8'h00);
        bus.i_otp_strobe = 1'b0;
        tick();
        idle_pins();
        if (clr) m_err = 4'h0;
        m_err = m_err | 4'h2;
    endtask

    // Chip select lost k cycles into a read strobe.
    task automatic do_abort(input logic [6:0] a, input int k);
        bus.i_otp_load   = 1'b1;
        bus.i_otp_pgenb  = 1'b1;
        bus.i_otp_addr   = a;
        bus.i_otp_strobe = 1'b1;
        for (int i = 0; i < k; i++) tick();
        bus.i_otp_csb = 1'b1;
        tick();
        check("abort.busy", {7'h00, bus.o_busy}, 8'h00);
        bus.i_otp_strobe = 1'b0;
        tick();
        bus.i_otp_csb = 1'b0;
        tick();
        idle_pins();
        m_err = m_err | 4'h8;
    endtask

    task automatic do_clear();
        bus.i_err_clr = 1'b1;
        tick();
        bus.i_err_clr = 1'b0;
        m_err = 4'h0;
    endtask

    initial begin
        int op;
        logic [6:0] a;
        int len;
        int drop;

        bus.i_otp_csb  = 1'b1;
        bus.i_otp_addr = 7'h00;
        idle_pins();
        model_reset();

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check_all("reset");
        rst_n = 1'b0;
        rst_n = 1'b1;
        bus.i_otp_csb = 1'b0;
        tick();

        // Fresh read of byte 2
        do_read(7'h10, 3, -1);
        check_all("rd_fresh");
        check("rd_fresh.q_const", bus.o_otp_q, 8'h00);

        // Program byte 2 bit 3, read back
        do_prog(7'h13, 8, -1);
        check_all("pg_13");
        check("pg_13.cnt_const", bus.o_pg_cnt, 8'h01);
        do_read(7'h10, 3, -1);
        check_all("rd_after_pg");
        check("rd_after_pg.q_const", bus.o_otp_q, 8'h08);

        // Short program pulse
        do_prog(7'h00, 3, -1);
        check("pg_short.err_const", {4'h0, bus.o_err}, 8'h01);
        do_read(7'h00, 3, -1);
        check_all("rd_after_short");
        do_clear();
        check_all("clr1");

        // Supply loss in the 4th strobe cycle
        do_prog(7'h21, 8, 3);
        check_all("pg_vdd_loss");
        do_read(7'h20, 3, -1);
        check_all("rd_after_loss");
        do_clear();

        // Abort, then clear
        do_abort(7'h10, 2);
        check_all("abort");
        do_clear();
        check_all("clr2");

        // Illegal mode, then illegal with simultaneous clear over an older short error
        do_illegal(1'b0);
        check_all("illegal");
        do_read(7'h10, 1, -1);
        check_all("rd_short");
        do_illegal(1'b1);
        check_all("illegal_clr");
        check("illegal_clr.err_const", {4'h0, bus.o_err}, 8'h02);
        do_clear();

        // Address change mid-read returns the latched byte
        do_prog(7'h2D, 8, -1);
        do_read(7'h28, 5, 2);
        check_all("rd_toggle");

        // Pulse-width boundaries
        do_clear();
        do_read(7'h10, RD_MIN + 1, -1);
        check_all("rd_bound_ok");
        do_read(7'h10, RD_MIN, -1);
        check_all("rd_bound_short");
        do_prog(7'h45, PG_MIN + 1, -1);
        check_all("pg_bound_ok");
        do_prog(7'h46, PG_MIN, -1);
        check_all("pg_bound_short");
        do_clear();

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(9, 0);
            a  = 7'($urandom_range(127, 0));
            if (op < 4) begin
                len = $urandom_range(6, 1);
                do_read(a, len, (op == 0 && len >= 3) ? 1 : -1);
                check_all("rnd_rd");
            end else if (op < 8) begin
                len  = $urandom_range(10, 3);
                drop = ($urandom_range(3, 0) == 0) ? $urandom_range(len - 1, 1) : -1;
                do_prog(a, len, drop);
                check_all("rnd_pg");
            end else if (op == 8) begin
                do_clear();
                check_all("rnd_clr");
            end else begin
                do_abort(a, $urandom_range(3, 1));
                check_all("rnd_abort");
            end
        end

        // Program count saturation (re-programming set bits still counts)
        for (int n = 0; n < 260; n++) do_prog(7'h7F, PG_MIN + 1, -1);
        check_all("pg_sat");
        check("pg_sat.cnt_const", bus.o_pg_cnt, 8'hFF);

        // Reset mid-program abandons the access
        bus.i_otp_load   = 1'b0;
        bus.i_otp_pgenb  = 1'b0;
        bus.i_otp_vddqsw = 1'b1;
        bus.i_otp_addr   = 7'h3A;
        bus.i_otp_strobe = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        bus.i_otp_strobe = 1'b0;
        tick();
        model_reset();
        check_all("rst_mid");
        rst_n = 1'b1;
        idle_pins();
        tick();
        do_read(7'h38, 3, -1);
        check_all("rd_after_rst");
        do_read(7'h10, 3, -1);
        check_all("rd_init_byte2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
